sw_seq_mem_server: RTL

//  Synthesizable responder for the SmithWaterman sequence-fetch port. It holds a target (T) bank and a

---
 rtl/sw_seq_mem_server.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sw_seq_mem_server.sv
// ---------------------------------------------------------------------------
// sw_seq_mem_server
//
// Sequence-fetch responder for the SmithWaterman core. Holds a target (T)
// bank and a query (Q) bank and returns the addressed word combinationally
// so the core can sample it on the next rising edge. A host burst-load port
// refills one bank at a time while the core is idle; any load request or
// in-progress burst that meets core_busy_i is refused or aborted and
// flagged on conflict_o.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   select_T_i, addr_i         core read request (1 = T bank, 0 = Q bank)
//   data_o                     read word, 0 beyond the bank's loaded length
//   core_busy_i                core busy; blocks/aborts loading
//   load_req_i, load_bank_i    start a burst into the chosen bank
//   wr_valid_i, wr_data_i,
//   wr_last_i, wr_ready_o      host burst word stream
//   t_count_o, q_count_o       valid word count per bank (0..DEPTH)
//   load_done_o                one-cycle pulse after a burst ends on wr_last_i
//   overflow_o, conflict_o     sticky error flags
//   clr_err_i                  clears both flags (wins over a same-cycle set)
// ---------------------------------------------------------------------------
module sw_seq_mem_server #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              select_T_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [WORD_W-1:0] data_o,
    input  logic              core_busy_i,
    input  logic              load_req_i,
    input  logic              load_bank_i,
    input  logic              wr_valid_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    output logic [ADDR_W:0]   t_count_o,
    output logic [ADDR_W:0]   q_count_o,
    output logic              load_done_o,
    output logic              overflow_o,
    output logic              conflict_o,
    input  logic              clr_err_i
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              bank_q, bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   t_count_q, t_count_d;
    logic [ADDR_W:0]   q_count_q, q_count_d;
    logic              load_done_q, load_done_d;
    logic              overflow_q, overflow_d;
    logic              conflict_q, conflict_d;

    logic              wr_en;
    logic              set_overflow;
    logic              set_conflict;
    logic [ADDR_W:0]   next_count;

    logic [WORD_W-1:0] mem_t [DEPTH];
    logic [WORD_W-1:0] mem_q [DEPTH];

    // Count after the word at wr_ptr_q lands; one bit wider so DEPTH fits.
    assign next_count = {1'b0, wr_ptr_q} + 1'b1;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        wr_ptr_d     = wr_ptr_q;
        t_count_d    = t_count_q;
        q_count_d    = q_count_q;
        load_done_d  = 1'b0;
        wr_en        = 1'b0;
        set_overflow = 1'b0;
        set_conflict = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_req_i) begin
                    if (core_busy_i) begin
                        set_conflict = 1'b1;
                    end else begin
                        state_d  = ST_LOAD;
                        bank_d   = load_bank_i;
                        wr_ptr_d = '0;
                        if (load_bank_i) t_count_d = '0;
                        else             q_count_d = '0;
                    end
                end
            end

            ST_LOAD: begin
                // Busy is checked before the write so the core never sees a
                // bank change under it; words already written stay counted.
                if (core_busy_i) begin
                    set_conflict = 1'b1;
                    state_d      = ST_IDLE;
                end else if (wr_valid_i) begin
                    wr_en = 1'b1;
                    if (bank_q) t_count_d = next_count;
                    else        q_count_d = next_count;

                    if (wr_last_i) begin
                        load_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (&wr_ptr_q) begin
                        // Bank full without a terminating word.
                        set_overflow = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Clear wins over a set in the same cycle.
        overflow_d = clr_err_i ? 1'b0 : (overflow_q | set_overflow);
        conflict_d = clr_err_i ? 1'b0 : (conflict_q | set_conflict);
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bank_q      <= 1'b0;
            wr_ptr_q    <= '0;
            t_count_q   <= '0;
            q_count_q   <= '0;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            wr_ptr_q    <= wr_ptr_d;
            t_count_q   <= t_count_d;
            q_count_q   <= q_count_d;
            load_done_q <= load_done_d;
            overflow_q  <= overflow_d;
            conflict_q  <= conflict_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage: no reset, contents are qualified by the counts.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (bank_q) mem_t[wr_ptr_q] <= wr_data_i;
            else        mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Zero-latency read. Anything at or past the loaded length reads as 0,
    // which the core uses as padding/terminator. A read of the word being
    // written this cycle sees the pre-edge memory and count.
    // -----------------------------------------------------------------------
    logic [ADDR_W:0]   rd_count;
    logic [WORD_W-1:0] rd_word;

    always_comb begin
        rd_count = select_T_i ? t_count_q : q_count_q;
        rd_word  = select_T_i ? mem_t[addr_i] : mem_q[addr_i];
        data_o   = ({1'b0, addr_i} < rd_count) ? rd_word : '0;
    end

    // Ready drops on a busy cycle so the host never sees a refused word
    // handshaken.
    assign wr_ready_o  = (state_q == ST_LOAD) && !core_busy_i;
    assign t_count_o   = t_count_q;
    assign q_count_o   = q_count_q;
    assign load_done_o = load_done_q;
    assign overflow_o  = overflow_q;
    assign conflict_o  = conflict_q;

endmodule
